// File: rtl/edge_detector_pkg.sv
// Shared defaults and legal parameter ranges for the edge detector block.
package edge_detector_pkg;

    localparam int WIDTH_DEF       = 1;
    localparam int WIDTH_MIN       = 1;
    localparam int WIDTH_MAX       = 64;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Width of the warm-up counter; must hold values up to SYNC_STAGES_MAX.
    localparam int WARM_CNT_W      = 3;

endpackage

// File: rtl/edge_detector_sync.sv
// Per-bit flop-chain synchronizer placed in front of the edge history register.
// Only instantiated when EDGE_DETECTOR_SYNC_EN is defined.
module edge_detector_sync
    import edge_detector_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // Shift the input through the chain; reset flushes every stage to zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/edge_detector.sv
// Per-bit rising/falling edge detector with one-cycle output pulses.
// Optional macro EDGE_DETECTOR_SYNC_EN inserts a SYNC_STAGES-deep synchronizer
// in front of the history register; without it detection is combinational
// (zero-cycle latency from a_i to the pulse outputs).
module edge_detector
    import edge_detector_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] rising_edge_o,
    output logic [WIDTH-1:0] falling_edge_o
);

    // Reject out-of-range configurations at elaboration time.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("edge_detector: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("edge_detector: SYNC_STAGES %0d outside %0d..%0d",
               SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    logic [WIDTH-1:0] a_s;      // value compared against history this cycle
    logic [WIDTH-1:0] a_q;      // value sampled at the previous clock edge
    logic             primed;   // history is valid; outputs may pulse

`ifdef EDGE_DETECTOR_SYNC_EN
    logic [WARM_CNT_W-1:0] warm_cnt;

    edge_detector_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (a_i),
        .q_o   (a_s)
    );

    // Hold off detection until the synchronizer and history are both filled
    // with real samples (SYNC_STAGES+1 edges after release).
    always_ff @(posedge clk) begin
        if (!reset) begin
            warm_cnt <= '0;
            primed   <= 1'b0;
        end else if (!primed) begin
            warm_cnt <= warm_cnt + 1'b1;
            if (warm_cnt == WARM_CNT_W'(SYNC_STAGES)) begin
                primed <= 1'b1;
            end
        end
    end
`else
    assign a_s = a_i;

    // Detection becomes valid one edge after reset release, once a_q holds a real sample.
    always_ff @(posedge clk) begin
        if (!reset) begin
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
        end
    end
`endif

    // History register: remembers the previous sampled value of every bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q <= '0;
        end else begin
            a_q <= a_s;
        end
    end

    // Pulse outputs, forced to zero during reset and before priming so a level
    // already high at release never looks like an edge.
    always_comb begin
        rising_edge_o  = '0;
        falling_edge_o = '0;
        if (reset && primed) begin
            rising_edge_o  =  a_s & ~a_q;
            falling_edge_o = ~a_s &  a_q;
        end
    end

endmodule

// File: tb/tb_edge_detector.sv
// Self-checking bench for edge_detector in its default (unsynchronized) build.
module tb_edge_detector;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] a_i;
    logic [W-1:0] rising_edge_o;
    logic [W-1:0] falling_edge_o;

    int n_tests;
    int n_fail;

    typedef struct {
        logic         rst;
        logic [W-1:0] a;
        logic [W-1:0] exp_r;
        logic [W-1:0] exp_f;
        string        name;
    } vec_t;

    typedef struct {
        logic         rst;
        logic [W-1:0] a;
    } cyc_t;

    vec_t vecs[$];
    cyc_t hist[$];   // every applied cycle, oldest first

    edge_detector #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .a_i            (a_i),
        .rising_edge_o  (rising_edge_o),
        .falling_edge_o (falling_edge_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle just after the rising edge and record it in the history.
    task automatic drive(input logic r, input logic [W-1:0] a);
        @(posedge clk);
        #1;
        reset = r;
        a_i   = a;
        hist.push_back('{rst: r, a: a});
    endtask

    // Drive one cycle and compare both outputs mid-cycle against given values.
    task automatic step(input logic r, input logic [W-1:0] a,
                        input logic [W-1:0] er, input logic [W-1:0] ef, input string name);
        drive(r, a);
        @(negedge clk);
        chk({name, ".rise"}, rising_edge_o, er);
        chk({name, ".fall"}, falling_edge_o, ef);
    endtask

    // Reference: an edge exists only if this cycle and the one before were both
    // out of reset; it is then the difference between the two sampled values.
    function automatic logic [W-1:0] model_edge(input bit rising);
        cyc_t cur;
        cyc_t prv;
        cur = hist[hist.size()-1];
        if (hist.size() < 2 || !cur.rst) return '0;
        prv = hist[hist.size()-2];
        if (!prv.rst) return '0;
        return rising ? (cur.a & ~prv.a) : (~cur.a & prv.a);
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        a_i     = '0;

        // Reset entry with a held-high input, then 5 released cycles high.
        vecs.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0000, "rst_hold_hi"});
        vecs.push_back('{1'b1, 4'b0001, 4'b0000, 4'b0000, "release_hi"});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b1, 4'b0001, 4'b0000, 4'b0000, "steady_hi"});
        // Falling edge, then quiet low level.
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0001, "fall"});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, "hold_lo"});
        // Single rising edge lasts one cycle.
        vecs.push_back('{1'b1, 4'b0001, 4'b0001, 4'b0000, "rise"});
        vecs.push_back('{1'b1, 4'b0001, 4'b0000, 4'b0000, "rise_once"});
        // Toggle every cycle: alternating pulses, never coincident.
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0001, "toggle0"});
        vecs.push_back('{1'b1, 4'b0001, 4'b0001, 4'b0000, "toggle1"});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0001, "toggle2"});
        vecs.push_back('{1'b1, 4'b0001, 4'b0001, 4'b0000, "toggle3"});
        // Independent bits with simultaneous opposite edges.
        vecs.push_back('{1'b1, 4'b1010, 4'b1010, 4'b0001, "indep"});
        vecs.push_back('{1'b1, 4'b0101, 4'b0101, 4'b1010, "indep_swap"});

        // Plain reset state with low input.
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, "reset_state");
        step(1'b0, 4'b1111, 4'b0000, 4'b0000, "reset_ignores_in");

        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].a, vecs[i].exp_r, vecs[i].exp_f, vecs[i].name);

        // Reset lands in the cycle the input rises: pulse killed, none after release.
        step(1'b1, 4'b0000, 4'b0000, 4'b0101, "pre_kill_fall");
        step(1'b0, 4'b1111, 4'b0000, 4'b0000, "kill_mid_pulse");
        step(1'b1, 4'b1111, 4'b0000, 4'b0000, "post_release");
        step(1'b1, 4'b1111, 4'b0000, 4'b0000, "post_release_hold");
        step(1'b1, 4'b0000, 4'b0000, 4'b1111, "resume_fall");

        // Random stimulus against the history-based reference.
        for (int i = 0; i < 32; i++) begin
            drive(($urandom_range(0, 7) != 0), W'($urandom));
            @(negedge clk);
            chk("rand.rise", rising_edge_o, model_edge(1'b1));
            chk("rand.fall", falling_edge_o, model_edge(1'b0));
            chk("rand.excl", rising_edge_o & falling_edge_o, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
